cpu_simple_fetch: RTL and testbench

//  Instruction fetch stage directly upstream of the cpu_simple decode/execute core.

---
 rtl/cpu_simple_fetch.sv | 144 ++++++++++++++
 tb/tb_cpu_simple_fetch.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_simple_fetch.sv
// cpu_simple_fetch: instruction fetch stage feeding the cpu_simple decode/execute core.
// Holds the PC and a small writable instruction memory, and presents one registered
// instruction per cycle on a valid/ready handshake. Branch redirects come from execute,
// and fetching stops on the HALT opcode.
// Optional feature: define CPU_SIMPLE_FETCH_PERF_EN to build the saturating accepted-
// instruction counter on fetch_count. Without it, fetch_count is tied to zero.
module cpu_simple_fetch #(
   parameter int unsigned            PC_W     = 4,
   parameter int unsigned            INSTR_W  = 8,
   parameter logic [PC_W-1:0]        RESET_PC = '0,
   parameter logic [INSTR_W-1:0]     HALT_OP  = INSTR_W'(8'hFF)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_en,
   input  logic [PC_W-1:0]     load_addr,
   input  logic [INSTR_W-1:0]  load_data,
   input  logic                br_taken,
   input  logic [PC_W-1:0]     br_target,
   input  logic                instr_ready,
   output logic                instr_valid,
   output logic [INSTR_W-1:0]  instr,
   output logic [PC_W-1:0]     instr_pc,
   output logic [PC_W-1:0]     out_PC,
   output logic                halted,
   output logic [15:0]         fetch_count
);

   localparam int unsigned DEPTH = 1 << PC_W;

   typedef enum logic {
      S_RUN    = 1'b0,
      S_HALTED = 1'b1
   } state_t;

   state_t               r_state;
   logic [PC_W-1:0]      r_pc;
   logic [INSTR_W-1:0]   r_instr;
   logic [PC_W-1:0]      r_instr_pc;
   logic                 r_valid;
   logic [INSTR_W-1:0]   r_mem [DEPTH];

   state_t               w_state_nxt;
   logic [PC_W-1:0]      w_pc_nxt;
   logic [INSTR_W-1:0]   w_instr_nxt;
   logic [PC_W-1:0]      w_instr_pc_nxt;
   logic                 w_valid_nxt;
   logic [PC_W-1:0]      w_fetch_addr;
   logic [INSTR_W-1:0]   w_fetch_word;
   logic                 w_do_fetch;
   logic                 w_slot_free;

   assign w_slot_free = !r_valid || instr_ready;

   // Program-load port; the memory is deliberately not reset so a program survives rst.
   always_ff @(posedge clk) begin
      if (load_en) begin
         r_mem[load_addr] <= load_data;
      end
   end

   // State and fetch-output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_RUN;
         r_pc       <= RESET_PC;
         r_instr    <= '0;
         r_instr_pc <= '0;
         r_valid    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_instr    <= w_instr_nxt;
         r_instr_pc <= w_instr_pc_nxt;
         r_valid    <= w_valid_nxt;
      end
   end

   // Next-state logic: load beats redirect beats sequential fetch; halted only waits.
   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_instr_nxt    = r_instr;
      w_instr_pc_nxt = r_instr_pc;
      w_valid_nxt    = r_valid;
      w_fetch_addr   = r_pc;
      w_fetch_word   = '0;
      w_do_fetch     = 1'b0;

      if (load_en) begin
         // Memory write cycle: never fetch, so a same-address read can't race the write.
         if (br_taken) begin
            w_pc_nxt    = br_target;
            w_valid_nxt = 1'b0;
            w_state_nxt = S_RUN;
         end else if (instr_ready) begin
            w_valid_nxt = 1'b0;
         end
      end else if (br_taken) begin
         w_fetch_addr = br_target;
         w_do_fetch   = 1'b1;
      end else if (r_state == S_RUN && w_slot_free) begin
         w_do_fetch = 1'b1;
      end else if (r_state == S_HALTED && instr_ready) begin
         w_valid_nxt = 1'b0;
      end

      if (w_do_fetch) begin
         w_fetch_word   = r_mem[w_fetch_addr];
         w_instr_nxt    = w_fetch_word;
         w_instr_pc_nxt = w_fetch_addr;
         w_valid_nxt    = 1'b1;
         w_pc_nxt       = w_fetch_addr + PC_W'(1);
         w_state_nxt    = (w_fetch_word == HALT_OP) ? S_HALTED : S_RUN;
      end
   end

`ifdef CPU_SIMPLE_FETCH_PERF_EN
   logic [15:0] r_fetch_count;
   logic        w_accept;

   assign w_accept = r_valid && instr_ready;

   // Saturating count of instructions accepted by decode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_count <= 16'h0000;
      end else if (w_accept && r_fetch_count != 16'hFFFF) begin
         r_fetch_count <= r_fetch_count + 16'h0001;
      end
   end

   assign fetch_count = r_fetch_count;
`else
   assign fetch_count = 16'h0000;
`endif

   assign instr_valid = r_valid;
   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;
   assign out_PC      = r_pc;
   assign halted      = (r_state == S_HALTED);

endmodule

// File: tb/tb_cpu_simple_fetch.sv
// Directed testbench for cpu_simple_fetch (default parameters).
module tb_cpu_simple_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load_en = 1'b0;
   logic [3:0]  load_addr = '0;
   logic [7:0]  load_data = '0;
   logic        br_taken = 1'b0;
   logic [3:0]  br_target = '0;
   logic        instr_ready = 1'b0;
   logic        instr_valid;
   logic [7:0]  instr;
   logic [3:0]  instr_pc;
   logic [3:0]  out_PC;
   logic        halted;
   logic [15:0] fetch_count;

   int n_pass  = 0;
   int n_total = 0;

   logic [7:0] prog [16];
   logic [7:0] exp_word [4];

   cpu_simple_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .load_en     (load_en),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .instr_ready (instr_ready),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .out_PC      (out_PC),
      .halted      (halted),
      .fetch_count (fetch_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_default_prog();
      prog[0] = 8'h11; prog[1] = 8'h22; prog[2] = 8'h33; prog[3] = 8'h44;
      for (int i = 4; i < 16; i++) prog[i] = 8'h40 + 8'(i);
   endtask

   // Assert reset, write the whole program while reset is held, release between edges.
   task automatic reset_and_load();
      rst = 1'b1;
      br_taken = 1'b0;
      instr_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         load_en = 1'b1; load_addr = 4'(i); load_data = prog[i];
         tick();
      end
      load_en = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      n_total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", instr_valid); else n_pass++;
      n_total++; if (out_PC !== 4'h0) $display("FAIL reset_pc: got %h want 0", out_PC); else n_pass++;
      n_total++; if (instr !== 8'h00) $display("FAIL reset_instr: got %h want 00", instr); else n_pass++;
      n_total++; if (instr_pc !== 4'h0) $display("FAIL reset_instr_pc: got %h want 0", instr_pc); else n_pass++;
      n_total++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else n_pass++;
      n_total++; if (fetch_count !== 16'h0) $display("FAIL reset_count: got %h want 0", fetch_count); else n_pass++;
   endtask

   task automatic test_stream();
      logic [15:0] exp_cnt;
      set_default_prog();
      reset_and_load();
      instr_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_total++;
         if (instr_valid !== 1'b1 || instr !== exp_word[k] || instr_pc !== 4'(k) || out_PC !== 4'(k + 1))
            $display("FAIL stream_%0d: got v=%b i=%h pc=%h npc=%h want v=1 i=%h pc=%h npc=%h",
                     k, instr_valid, instr, instr_pc, out_PC, exp_word[k], 4'(k), 4'(k + 1));
         else n_pass++;
      end
      tick();
`ifdef CPU_SIMPLE_FETCH_PERF_EN
      exp_cnt = 16'd4;
`else
      exp_cnt = 16'd0;
`endif
      n_total++; if (fetch_count !== exp_cnt) $display("FAIL stream_count: got %0d want %0d", fetch_count, exp_cnt); else n_pass++;
   endtask

   task automatic test_stall();
      set_default_prog();
      reset_and_load();
      instr_ready = 1'b1;
      tick();
      tick();
      instr_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_total++;
         if (instr_valid !== 1'b1 || instr !== 8'h22 || instr_pc !== 4'h1 || out_PC !== 4'h2)
            $display("FAIL stall_hold_%0d: got v=%b i=%h pc=%h npc=%h want v=1 i=22 pc=1 npc=2",
                     k, instr_valid, instr, instr_pc, out_PC);
         else n_pass++;
      end
      instr_ready = 1'b1;
      tick();
      n_total++;
      if (instr !== 8'h33 || instr_pc !== 4'h2 || out_PC !== 4'h3)
         $display("FAIL stall_resume: got i=%h pc=%h npc=%h want i=33 pc=2 npc=3", instr, instr_pc, out_PC);
      else n_pass++;
   endtask

   task automatic test_halt();
      set_default_prog();
      prog[2] = 8'hFF;
      reset_and_load();
      instr_ready = 1'b1;
      tick();
      n_total++; if (instr !== 8'h11 || halted !== 1'b0) $display("FAIL halt_w0: got i=%h h=%b want i=11 h=0", instr, halted); else n_pass++;
      tick();
      tick();
      n_total++;
      if (instr !== 8'hFF || instr_pc !== 4'h2 || instr_valid !== 1'b1 || halted !== 1'b1 || out_PC !== 4'h3)
         $display("FAIL halt_word: got i=%h pc=%h v=%b h=%b npc=%h want i=ff pc=2 v=1 h=1 npc=3",
                  instr, instr_pc, instr_valid, halted, out_PC);
      else n_pass++;
      tick();
      n_total++;
      if (instr_valid !== 1'b0 || halted !== 1'b1 || out_PC !== 4'h3)
         $display("FAIL halt_idle: got v=%b h=%b npc=%h want v=0 h=1 npc=3", instr_valid, halted, out_PC);
      else n_pass++;
      br_taken = 1'b1; br_target = 4'h0;
      tick();
      br_taken = 1'b0;
      n_total++;
      if (instr !== 8'h11 || instr_pc !== 4'h0 || instr_valid !== 1'b1 || halted !== 1'b0 || out_PC !== 4'h1)
         $display("FAIL halt_exit: got i=%h pc=%h v=%b h=%b npc=%h want i=11 pc=0 v=1 h=0 npc=1",
                  instr, instr_pc, instr_valid, halted, out_PC);
      else n_pass++;
   endtask

   task automatic test_wrap();
      set_default_prog();
      prog[15] = 8'hAA;
      reset_and_load();
      instr_ready = 1'b1;
      br_taken = 1'b1; br_target = 4'hF;
      tick();
      br_taken = 1'b0;
      n_total++;
      if (instr !== 8'hAA || instr_pc !== 4'hF || out_PC !== 4'h0)
         $display("FAIL wrap_f: got i=%h pc=%h npc=%h want i=aa pc=f npc=0", instr, instr_pc, out_PC);
      else n_pass++;
      tick();
      n_total++;
      if (instr !== 8'h11 || instr_pc !== 4'h0 || out_PC !== 4'h1)
         $display("FAIL wrap_0: got i=%h pc=%h npc=%h want i=11 pc=0 npc=1", instr, instr_pc, out_PC);
      else n_pass++;
   endtask

   task automatic test_branch_stall();
      set_default_prog();
      reset_and_load();
      instr_ready = 1'b1;
      tick();
      tick();
      instr_ready = 1'b0;
      br_taken = 1'b1; br_target = 4'h3;
      tick();
      br_taken = 1'b0;
      n_total++;
      if (instr !== 8'h44 || instr_pc !== 4'h3 || out_PC !== 4'h4 || instr_valid !== 1'b1)
         $display("FAIL br_stall: got i=%h pc=%h npc=%h v=%b want i=44 pc=3 npc=4 v=1",
                  instr, instr_pc, out_PC, instr_valid);
      else n_pass++;
      tick();
      n_total++;
      if (instr !== 8'h44 || out_PC !== 4'h4)
         $display("FAIL br_stall_hold: got i=%h npc=%h want i=44 npc=4", instr, out_PC);
      else n_pass++;
   endtask

   task automatic test_load_priority();
      set_default_prog();
      reset_and_load();
      instr_ready = 1'b1;
      tick();
      load_en = 1'b1; load_addr = 4'h9; load_data = 8'h99;
      tick();
      n_total++;
      if (instr_valid !== 1'b0 || out_PC !== 4'h1)
         $display("FAIL load_block: got v=%b npc=%h want v=0 npc=1", instr_valid, out_PC);
      else n_pass++;
      load_addr = 4'hA; load_data = 8'h77;
      br_taken = 1'b1; br_target = 4'h9;
      tick();
      n_total++;
      if (instr_valid !== 1'b0 || out_PC !== 4'h9)
         $display("FAIL load_branch: got v=%b npc=%h want v=0 npc=9", instr_valid, out_PC);
      else n_pass++;
      load_en = 1'b0; br_taken = 1'b0;
      tick();
      n_total++;
      if (instr !== 8'h99 || instr_pc !== 4'h9 || out_PC !== 4'hA)
         $display("FAIL load_fetch9: got i=%h pc=%h npc=%h want i=99 pc=9 npc=a", instr, instr_pc, out_PC);
      else n_pass++;
      tick();
      n_total++;
      if (instr !== 8'h77 || instr_pc !== 4'hA)
         $display("FAIL load_fetch10: got i=%h pc=%h want i=77 pc=a", instr, instr_pc);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      set_default_prog();
      reset_and_load();
      instr_ready = 1'b1;
      tick();
      tick();
      tick();
      #3 rst = 1'b1;
      #1;
      n_total++;
      if (instr_valid !== 1'b0 || out_PC !== 4'h0 || halted !== 1'b0 || fetch_count !== 16'h0)
         $display("FAIL async_rst: got v=%b npc=%h h=%b cnt=%0d want v=0 npc=0 h=0 cnt=0",
                  instr_valid, out_PC, halted, fetch_count);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      tick();
      n_total++;
      if (instr !== 8'h11 || instr_pc !== 4'h0 || out_PC !== 4'h1)
         $display("FAIL async_restart: got i=%h pc=%h npc=%h want i=11 pc=0 npc=1", instr, instr_pc, out_PC);
      else n_pass++;
   endtask

   initial begin
      exp_word[0] = 8'h11; exp_word[1] = 8'h22; exp_word[2] = 8'h33; exp_word[3] = 8'h44;
      test_reset();
      test_stream();
      test_stall();
      test_halt();
      test_wrap();
      test_branch_stall();
      test_load_priority();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
